// File: rtl/switchbox_cfg_loader.sv
// Serial configuration loader for the switch matrix: sync-word detect, shadow load, word
// validation and atomic commit. Optional parity check enabled by defining CFG_PARITY_EN.
module switchbox_cfg_loader #(
  parameter int unsigned NTB       = 5,
  parameter int unsigned NLR       = 4,
  parameter int unsigned DW        = 6,
  parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_din,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [NTB*DW-1:0]   cfg_top,
  output logic [NTB*DW-1:0]   cfg_bottom,
  output logic [NLR*DW-1:0]   cfg_left,
  output logic [NLR*DW-1:0]   cfg_right,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int unsigned NWORDS = 2 * NTB + 2 * NLR;
  localparam int unsigned NBITS  = NWORDS * DW;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SYNC   = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [7:0]       sync_q, sync_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       wbit_q, wbit_d;
  logic             invalid_q, invalid_d;
`ifdef CFG_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             accept, clear, commit_en;
  logic [DW-1:0]    word_now;

  logic [NTB*DW-1:0] top_q, bottom_q;
  logic [NLR*DW-1:0] left_q, right_q;

  // Select 0 leaves the pin undriven, so its index is don't-care.
  function automatic logic word_legal(input logic [DW-1:0] w);
    logic [2:0] sel;
    logic [2:0] idx;
    sel = w[2:0];
    idx = w[5:3];
    case (sel)
      3'd0:       word_legal = 1'b1;
      3'd1, 3'd3: word_legal = 32'(idx) < NTB;
      3'd2, 3'd4: word_legal = 32'(idx) < NLR;
      default:    word_legal = 1'b0;
    endcase
  endfunction

`ifdef CFG_PARITY_EN
  assign cfg_ready = (state_q == SYNC) || (state_q == LOAD) || (state_q == CHECK);
`else
  assign cfg_ready = (state_q == SYNC) || (state_q == LOAD);
`endif
  assign cfg_done  = (state_q == DONE);
  assign cfg_err   = (state_q == ERROR);
  assign accept    = cfg_valid && cfg_ready;
  assign word_now  = {shadow_q[DW-2:0], cfg_din};
  assign commit_en = (state_q == COMMIT) && !invalid_q;

  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    wbit_d    = wbit_q;
    invalid_d = invalid_q;
`ifdef CFG_PARITY_EN
    par_d     = par_q;
`endif
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) clear = 1'b1;
      end
      SYNC: begin
        if (cfg_start) begin
          clear = 1'b1;
        end else if (accept) begin
          sync_d = {sync_q[6:0], cfg_din};
          if (sync_d == SYNC_WORD) begin
            state_d   = LOAD;
            bit_cnt_d = '0;
            wbit_d    = '0;
            invalid_d = 1'b0;
          end
        end
      end
      LOAD: begin
        if (cfg_start) begin
          clear = 1'b1;
        end else if (accept) begin
          shadow_d = {shadow_q[NBITS-2:0], cfg_din};
`ifdef CFG_PARITY_EN
          par_d    = par_q ^ cfg_din;
`endif
          if (wbit_q == 3'(DW - 1)) begin
            wbit_d = '0;
            if (!word_legal(word_now)) invalid_d = 1'b1;
          end else begin
            wbit_d = wbit_q + 3'd1;
          end
          if (bit_cnt_q == 7'(NBITS - 1)) begin
`ifdef CFG_PARITY_EN
            state_d = CHECK;
`else
            state_d = COMMIT;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end
`ifdef CFG_PARITY_EN
      CHECK: begin
        if (cfg_start) begin
          clear = 1'b1;
        end else if (accept) begin
          // Even parity: payload ones plus the parity bit must be even.
          if (par_q ^ cfg_din) invalid_d = 1'b1;
          state_d = COMMIT;
        end
      end
`endif
      COMMIT: begin
        state_d = invalid_q ? ERROR : DONE;
      end
      DONE, ERROR: begin
        if (cfg_start) clear = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d   = SYNC;
      sync_d    = '0;
      shadow_d  = '0;
      bit_cnt_d = '0;
      wbit_d    = '0;
      invalid_d = 1'b0;
`ifdef CFG_PARITY_EN
      par_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      wbit_q    <= '0;
      invalid_q <= 1'b0;
`ifdef CFG_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      wbit_q    <= wbit_d;
      invalid_q <= invalid_d;
`ifdef CFG_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // The first payload word shifts furthest, ending up at the top of the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q    <= '0;
      bottom_q <= '0;
      left_q   <= '0;
      right_q  <= '0;
    end else if (commit_en) begin
      for (int i = 0; i < NTB; i++) begin
        top_q[i*DW +: DW]    <= shadow_q[NBITS-1-i*DW -: DW];
        bottom_q[i*DW +: DW] <= shadow_q[NBITS-1-(NTB+i)*DW -: DW];
      end
      for (int i = 0; i < NLR; i++) begin
        left_q[i*DW +: DW]   <= shadow_q[NBITS-1-(2*NTB+i)*DW -: DW];
        right_q[i*DW +: DW]  <= shadow_q[NBITS-1-(2*NTB+NLR+i)*DW -: DW];
      end
    end
  end

  assign cfg_top    = top_q;
  assign cfg_bottom = bottom_q;
  assign cfg_left   = left_q;
  assign cfg_right  = right_q;

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Self-checking bench for switchbox_cfg_loader: directed and randomized loads against a
// word-level model of the committed configuration. Honours CFG_PARITY_EN when defined.
module tb_switchbox_cfg_loader;

  localparam int NTB = 5;
  localparam int NLR = 4;
  localparam int DW  = 6;
  localparam int NW  = 2 * NTB + 2 * NLR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_start = 1'b0;
  logic cfg_din = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready, cfg_done, cfg_err;
  logic [NTB*DW-1:0] cfg_top, cfg_bottom;
  logic [NLR*DW-1:0] cfg_left, cfg_right;

  int n_checks = 0;
  int n_err = 0;

  logic [5:0] tx_words [NW];
  logic [5:0] cur_words [NW];
  logic       exp_done = 1'b0;
  logic       exp_err = 1'b0;

  switchbox_cfg_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_din    (cfg_din),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_top    (cfg_top),
    .cfg_bottom (cfg_bottom),
    .cfg_left   (cfg_left),
    .cfg_right  (cfg_right),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, required finish within 600us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] w);
    int sel = int'(w[2:0]);
    int idx = int'(w[5:3]);
    if (sel == 0) return 1'b1;
    if (sel == 1 || sel == 3) return idx < NTB;
    if (sel == 2 || sel == 4) return idx < NLR;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_bus(input int base, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r[i*DW +: DW] = cur_words[base+i];
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, " top"},    64'(cfg_top),    exp_bus(0, NTB));
    check({tag, " bottom"}, 64'(cfg_bottom), exp_bus(NTB, NTB));
    check({tag, " left"},   64'(cfg_left),   exp_bus(2 * NTB, NLR));
    check({tag, " right"},  64'(cfg_right),  exp_bus(2 * NTB + NLR, NLR));
    check({tag, " done"},   64'(cfg_done),   64'(exp_done));
    check({tag, " err"},    64'(cfg_err),    64'(exp_err));
  endtask

  task automatic clear_words();
    for (int i = 0; i < NW; i++) tx_words[i] = 6'h00;
  endtask

  task automatic random_words(input bool_bad);
    for (int i = 0; i < NW; i++) begin
      logic [5:0] w;
      do w = 6'($urandom); while (!legal(w));
      tx_words[i] = w;
    end
    if (bool_bad) begin
      logic [5:0] w;
      do w = 6'($urandom); while (legal(w));
      tx_words[$urandom_range(0, NW - 1)] = w;
    end
  endtask

  task automatic send_bit(input logic b, input bit stall);
    int gap = stall ? int'($urandom_range(0, 3)) : 0;
    for (int g = 0; g < gap; g++) begin
      cfg_valid = 1'b0;
      cfg_din   = 1'($urandom);
      @(negedge clk);
    end
    cfg_valid = 1'b1;
    cfg_din   = b;
    @(negedge clk);
  endtask

  task automatic send_preamble(input bit pre_ff, input bit stall);
    logic [15:0] pre = pre_ff ? 16'hFFA5 : 16'h00A5;
    int top = pre_ff ? 15 : 7;
    for (int i = top; i >= 0; i--) send_bit(pre[i], stall);
  endtask

  task automatic pulse_start();
    cfg_valid = 1'b0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("start ready", 64'(cfg_ready), 64'd1);
    check("start done",  64'(cfg_done),  64'd0);
    check("start err",   64'(cfg_err),   64'd0);
  endtask

  // Full load of tx_words; model updates the expected committed configuration.
  task automatic run_load(input string tag, input bit stall, input bit pre_ff,
                          input bit no_start, input bit flip_par);
    logic par = 1'b0;
    logic ok = 1'b1;
    if (!no_start) pulse_start();
    send_preamble(pre_ff, stall);
    for (int w = 0; w < NW; w++) begin
      logic [5:0] word = tx_words[w];
      ok &= legal(word);
      for (int b = DW - 1; b >= 0; b--) begin
        par ^= word[b];
        send_bit(word[b], stall);
      end
    end
`ifdef CFG_PARITY_EN
    check({tag, " check ready"}, 64'(cfg_ready), 64'd1);
    send_bit(par ^ flip_par, stall);
    if (flip_par) ok = 1'b0;
`endif
    cfg_valid = 1'b0;
    check({tag, " commit ready"}, 64'(cfg_ready), 64'd0);
    check({tag, " commit hold"}, 64'(cfg_top), exp_bus(0, NTB));
    @(negedge clk);
    if (ok) begin
      for (int i = 0; i < NW; i++) cur_words[i] = tx_words[i];
    end
    exp_done = ok;
    exp_err  = !ok;
    check_outputs(tag);
    check({tag, " idle ready"}, 64'(cfg_ready), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) cur_words[i] = 6'h00;
    #3;
    check("reset ready", 64'(cfg_ready), 64'd0);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle ready", 64'(cfg_ready), 64'd0);

    clear_words();
    tx_words[0] = 6'b010_010;
    run_load("valid", 1'b0, 1'b0, 1'b0, 1'b0);
    check("valid top0", 64'(cfg_top[5:0]), 64'h12);

    tx_words[NTB+1] = 6'b000_110;
    run_load("badsel", 1'b0, 1'b0, 1'b0, 1'b0);

    clear_words();
    tx_words[2*NTB+3] = 6'b100_010;
    run_load("badidx", 1'b0, 1'b0, 1'b0, 1'b0);
    tx_words[2*NTB+3] = 6'b100_001;
    run_load("goodidx", 1'b0, 1'b0, 1'b0, 1'b0);
    check("goodidx left3", 64'(cfg_left[23:18]), 64'h21);

    random_words(1'b0);
    run_load("stall", 1'b1, 1'b0, 1'b0, 1'b0);
    random_words(1'b0);
    run_load("nostall", 1'b0, 1'b0, 1'b0, 1'b0);
    random_words(1'b0);
    run_load("preff", 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort at payload bit 50 with a bit presented on the same edge as cfg_start.
    random_words(1'b0);
    pulse_start();
    send_preamble(1'b0, 1'b0);
    for (int k = 0; k < 50; k++) send_bit(tx_words[k / DW][DW - 1 - (k % DW)], 1'b0);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_din   = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("abort ready", 64'(cfg_ready), 64'd1);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    check_outputs("abort");
    random_words(1'b0);
    run_load("after abort", 1'b1, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      random_words(($urandom_range(0, 2) == 0));
      run_load("random", ($urandom_range(0, 1) == 1), 1'b0, 1'b0, 1'b0);
    end

`ifdef CFG_PARITY_EN
    random_words(1'b0);
    run_load("parity ok", 1'b0, 1'b0, 1'b0, 1'b0);
    random_words(1'b0);
    run_load("parity bad", 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    // Asynchronous reset part-way through a load.
    random_words(1'b0);
    pulse_start();
    send_preamble(1'b0, 1'b0);
    for (int k = 0; k < 30; k++) send_bit(tx_words[k / DW][DW - 1 - (k % DW)], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NW; i++) cur_words[i] = 6'h00;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    check("midreset ready", 64'(cfg_ready), 64'd0);
    check_outputs("midreset");
    cfg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset ready", 64'(cfg_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
